// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for a small register-file RAM.
// Zero-fills every entry after reset before granting either requester.
module regfile_write_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              CLKIN,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              WE,
    output logic              INIT_DONE
);
    typedef enum logic [1:0] {S_CLEAR, S_CLEAR_END, S_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic [ADDR_W-1:0]   r_waddr, w_waddr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic                r_we, w_we_nxt;
    logic                r_init_done, w_init_done_nxt;
    logic                r_last_grant, w_last_grant_nxt;
    logic                w_gnt0, w_gnt1, w_run;

    // On contention the requester that did not win last time gets the port.
    assign w_gnt0 = REQ0_VALID & (~REQ1_VALID | r_last_grant);
    assign w_gnt1 = REQ1_VALID & (~REQ0_VALID | ~r_last_grant);
    assign w_run  = (r_state == S_RUN) & ~RESET;

    assign REQ0_READY = w_run & w_gnt0;
    assign REQ1_READY = w_run & w_gnt1;

    assign WADDR     = r_waddr;
    assign WDATA     = r_wdata;
    assign WE        = r_we;
    assign INIT_DONE = r_init_done;

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_addr_nxt   = r_clr_addr;
        w_waddr_nxt      = r_waddr;
        w_wdata_nxt      = r_wdata;
        w_we_nxt         = 1'b0;
        w_init_done_nxt  = r_init_done;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            S_CLEAR: begin
                w_we_nxt       = 1'b1;
                w_waddr_nxt    = r_clr_addr;
                w_wdata_nxt    = '0;
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (&r_clr_addr) w_state_nxt = S_CLEAR_END;
            end
            // One idle edge after the last fill write drops WE and flags completion.
            S_CLEAR_END: begin
                w_init_done_nxt = 1'b1;
                w_state_nxt     = S_RUN;
            end
            S_RUN: begin
                if (REQ0_READY) begin
                    w_we_nxt         = 1'b1;
                    w_waddr_nxt      = REQ0_ADDR;
                    w_wdata_nxt      = REQ0_DATA;
                    w_last_grant_nxt = 1'b0;
                end else if (REQ1_READY) begin
                    w_we_nxt         = 1'b1;
                    w_waddr_nxt      = REQ1_ADDR;
                    w_wdata_nxt      = REQ1_DATA;
                    w_last_grant_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            r_state      <= S_CLEAR;
            r_clr_addr   <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_init_done  <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_addr   <= w_clr_addr_nxt;
            r_we         <= w_we_nxt;
            r_waddr      <= w_waddr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_init_done  <= w_init_done_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: zero-fill, single writes, round-robin, hold, reset.
module tb_regfile_write_arbiter;
    logic       CLKIN = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic [1:0] REQ0_ADDR = '0, REQ1_ADDR = '0;
    logic [7:0] REQ0_DATA = '0, REQ1_DATA = '0;
    logic       REQ0_READY, REQ1_READY, WE, INIT_DONE;
    logic [1:0] WADDR;
    logic [7:0] WDATA;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
        .CLKIN(CLKIN), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .WADDR(WADDR), .WDATA(WDATA), .WE(WE), .INIT_DONE(INIT_DONE)
    );

    always #5 CLKIN = ~CLKIN;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic test_reset_clear();
        RESET = 1'b1; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        REQ0_ADDR = 2'd3; REQ1_ADDR = 2'd2; REQ0_DATA = 8'hEE; REQ1_DATA = 8'hDD;
        tick();
        tick();
        n_tests++; if ({WE, INIT_DONE, REQ0_READY, REQ1_READY} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_state got we/init/rdy0/rdy1=%b exp 0000", {WE, INIT_DONE, REQ0_READY, REQ1_READY}); end
        n_tests++; if ({WADDR, WDATA} !== 10'd0) begin n_fail++;
            $display("FAIL reset_wbus got waddr=%0d wdata=%h exp 0/00", WADDR, WDATA); end
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if ({REQ0_READY, REQ1_READY} !== 2'b00) begin n_fail++;
                $display("FAIL clear_ready%0d got %b exp 00", i, {REQ0_READY, REQ1_READY}); end
            tick();
            n_tests++; if (WE !== 1'b1 || WADDR !== 2'(i) || WDATA !== 8'h00 || INIT_DONE !== 1'b0) begin n_fail++;
                $display("FAIL clear_wr%0d got we=%b waddr=%0d wdata=%h init=%b exp 1/%0d/00/0", i, WE, WADDR, WDATA, INIT_DONE, i); end
        end
        n_tests++; if ({REQ0_READY, REQ1_READY} !== 2'b00) begin n_fail++;
            $display("FAIL clear_last_ready got %b exp 00", {REQ0_READY, REQ1_READY}); end
        tick();
        n_tests++; if (WE !== 1'b0 || INIT_DONE !== 1'b1) begin n_fail++;
            $display("FAIL init_done got we=%b init=%b exp 0/1", WE, INIT_DONE); end
        n_tests++; if ({REQ0_READY, REQ1_READY} !== 2'b10) begin n_fail++;
            $display("FAIL first_grant got rdy0/rdy1=%b exp 10", {REQ0_READY, REQ1_READY}); end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        #1;
    endtask

    task automatic test_req0_single();
        REQ0_VALID = 1'b1; REQ0_ADDR = 2'd2; REQ0_DATA = 8'hA5;
        #1;
        n_tests++; if ({REQ0_READY, REQ1_READY} !== 2'b10) begin n_fail++;
            $display("FAIL single_ready got %b exp 10", {REQ0_READY, REQ1_READY}); end
        tick();
        REQ0_VALID = 1'b0;
        n_tests++; if (WE !== 1'b1 || WADDR !== 2'd2 || WDATA !== 8'hA5) begin n_fail++;
            $display("FAIL single_write got we=%b waddr=%0d wdata=%h exp 1/2/a5", WE, WADDR, WDATA); end
        tick();
        n_tests++; if (WE !== 1'b0 || WADDR !== 2'd2 || WDATA !== 8'hA5) begin n_fail++;
            $display("FAIL single_idle got we=%b waddr=%0d wdata=%h exp 0/2/a5", WE, WADDR, WDATA); end
    endtask

    task automatic test_back_to_back();
        REQ1_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            REQ1_ADDR = 2'(i); REQ1_DATA = 8'h30 + 8'(i);
            #1;
            n_tests++; if (REQ1_READY !== 1'b1) begin n_fail++;
                $display("FAIL b2b_ready%0d got %b exp 1", i, REQ1_READY); end
            tick();
            n_tests++; if (WE !== 1'b1 || WADDR !== 2'(i) || WDATA !== 8'h30 + 8'(i)) begin n_fail++;
                $display("FAIL b2b_write%0d got we=%b waddr=%0d wdata=%h exp 1/%0d/%h", i, WE, WADDR, WDATA, i, 8'h30 + 8'(i)); end
        end
        REQ1_VALID = 1'b0;
        tick();
        n_tests++; if (WE !== 1'b0) begin n_fail++;
            $display("FAIL b2b_end got we=%b exp 0", WE); end
    endtask

    task automatic test_round_robin();
        logic [7:0] d0, d1;
        logic       exp_g [4];
        logic [7:0] exp_wd [4];
        exp_g  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_wd = '{8'h10, 8'h20, 8'h11, 8'h21};
        d0 = 8'h10; d1 = 8'h20;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; REQ0_ADDR = 2'd1; REQ1_ADDR = 2'd1;
        for (int i = 0; i < 4; i++) begin
            REQ0_DATA = d0; REQ1_DATA = d1;
            #1;
            n_tests++; if ({REQ0_READY, REQ1_READY} !== (exp_g[i] ? 2'b01 : 2'b10)) begin n_fail++;
                $display("FAIL rr_grant%0d got rdy0/rdy1=%b exp grant %0d", i, {REQ0_READY, REQ1_READY}, exp_g[i]); end
            tick();
            n_tests++; if (WE !== 1'b1 || WADDR !== 2'd1 || WDATA !== exp_wd[i]) begin n_fail++;
                $display("FAIL rr_write%0d got we=%b waddr=%0d wdata=%h exp 1/1/%h", i, WE, WADDR, WDATA, exp_wd[i]); end
            if (exp_g[i]) d1 = d1 + 8'd1; else d0 = d0 + 8'd1;
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        tick();
    endtask

    task automatic test_hold_loser();
        REQ0_VALID = 1'b1; REQ0_ADDR = 2'd0; REQ0_DATA = 8'h77;
        REQ1_VALID = 1'b1; REQ1_ADDR = 2'd3; REQ1_DATA = 8'h5A;
        #1;
        n_tests++; if ({REQ0_READY, REQ1_READY} !== 2'b10) begin n_fail++;
            $display("FAIL hold_win got %b exp 10", {REQ0_READY, REQ1_READY}); end
        tick();
        REQ0_VALID = 1'b0;
        #1;
        n_tests++; if (WE !== 1'b1 || WDATA !== 8'h77 || REQ1_READY !== 1'b1) begin n_fail++;
            $display("FAIL hold_accept got we=%b wdata=%h rdy1=%b exp 1/77/1", WE, WDATA, REQ1_READY); end
        tick();
        REQ1_VALID = 1'b0;
        n_tests++; if (WE !== 1'b1 || WADDR !== 2'd3 || WDATA !== 8'h5A) begin n_fail++;
            $display("FAIL hold_write got we=%b waddr=%0d wdata=%h exp 1/3/5a", WE, WADDR, WDATA); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; REQ0_ADDR = 2'd1; REQ1_ADDR = 2'd1;
        REQ0_DATA = 8'h10; REQ1_DATA = 8'h20;
        tick();
        n_tests++; if (WE !== 1'b1 || WDATA !== 8'h10) begin n_fail++;
            $display("FAIL mid_pre got we=%b wdata=%h exp 1/10", WE, WDATA); end
        RESET = 1'b1;
        #1;
        n_tests++; if ({REQ0_READY, REQ1_READY} !== 2'b00) begin n_fail++;
            $display("FAIL mid_rst_ready got %b exp 00", {REQ0_READY, REQ1_READY}); end
        tick();
        n_tests++; if (WE !== 1'b0 || INIT_DONE !== 1'b0 || REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst got we=%b init=%b rdy=%b%b exp 0/0/00", WE, INIT_DONE, REQ0_READY, REQ1_READY); end
        RESET = 1'b0;
        tick();
        n_tests++; if (WE !== 1'b1 || WADDR !== 2'd0 || WDATA !== 8'h00) begin n_fail++;
            $display("FAIL mid_clear got we=%b waddr=%0d wdata=%h exp 1/0/00", WE, WADDR, WDATA); end
        repeat (4) tick();
        n_tests++; if (INIT_DONE !== 1'b1 || {REQ0_READY, REQ1_READY} !== 2'b10) begin n_fail++;
            $display("FAIL mid_reinit got init=%b rdy=%b exp 1/10", INIT_DONE, {REQ0_READY, REQ1_READY}); end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    endtask

    initial begin
        #2;
        test_reset_clear();
        test_req0_single();
        test_back_to_back();
        test_round_robin();
        test_hold_loser();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
